// File: rtl/vga_text_ctrl.sv
// vga_text_ctrl: character-cell text controller owning the 80x60 screen buffer.
// Accepts characters over a valid/ready handshake, places them at a hardware
// cursor, handles wrap/newline/CR/backspace, scrolls by rotating a top-row
// pointer, and clears the screen on reset or request.
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   vga_addr / vga_data         {x[6:0], logical row[5:0]} -> {fg, bg, ascii}
//   wr_valid / wr_ready         character handshake
//   wr_char, wr_fg, wr_bg       offered character and its colours
//   clr_req                     clear-screen request (level)
//   busy                        high while any clear is running
//   cursor_x, cursor_y          current cursor (logical row)
module vga_text_ctrl #(
    parameter int unsigned COLS   = 80,
    parameter int unsigned ROWS   = 60,
    parameter logic [11:0] DEF_FG = 12'hFFF,
    parameter logic [11:0] DEF_BG = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] vga_addr,
    output logic [31:0] vga_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_char,
    input  logic [11:0] wr_fg,
    input  logic [11:0] wr_bg,
    input  logic        clr_req,
    output logic        busy,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y
);

    localparam int unsigned XW    = 7;
    localparam int unsigned YW    = 6;
    localparam int unsigned SW    = YW + 1;
    localparam int unsigned AW    = XW + YW;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1 << AW;

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
    localparam logic [DW-1:0] BLANK  = {DEF_FG, DEF_BG, 8'h20};

    typedef enum logic [1:0] {
        IDLE,
        CLR_LINE,
        CLR_ALL
    } state_t;

    state_t         state;
    logic [YW-1:0]  top;
    logic [XW-1:0]  clr_x;
    logic [YW-1:0]  clr_y;
    logic [YW-1:0]  clr_row;

    logic [DW-1:0]  mem [DEPTH];

    logic           we;
    logic [AW-1:0]  waddr;
    logic [DW-1:0]  wdata;

    // Logical row to physical row; 7-bit sum so y+top never overflows.
    function automatic logic [YW-1:0] phys_row(input logic [YW-1:0] y,
                                               input logic [YW-1:0] t);
        logic [SW-1:0] sum;
        sum = {1'b0, y} + {1'b0, t};
        if (sum >= SW'(ROWS)) begin
            sum = sum - SW'(ROWS);
        end
        return sum[YW-1:0];
    endfunction

    logic          accept_c;
    logic          printable_c;
    logic          newline_c;
    logic          scroll_c;
    logic [YW-1:0] cur_phys_c;

    assign wr_ready    = (state == IDLE) && !clr_req;
    assign busy        = (state != IDLE);
    assign accept_c    = wr_valid && wr_ready;
    assign printable_c = (wr_char >= 8'h20) && (wr_char != 8'h7F);
    assign cur_phys_c  = phys_row(cursor_y, top);
    assign newline_c   = accept_c && ((printable_c && cursor_x == X_LAST) || wr_char == 8'h0A);
    assign scroll_c    = newline_c && (cursor_y == Y_LAST);

    // Single RAM write port: character/backspace writes in IDLE, blanking in clears.
    always_comb begin
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        case (state)
            IDLE: begin
                if (accept_c && printable_c) begin
                    we    = 1'b1;
                    waddr = {cursor_x, cur_phys_c};
                    wdata = {wr_fg, wr_bg, wr_char};
                end else if (accept_c && wr_char == 8'h08 && cursor_x != '0) begin
                    we    = 1'b1;
                    waddr = {cursor_x - XW'(1), cur_phys_c};
                    wdata = {wr_fg, wr_bg, 8'h20};
                end
            end
            CLR_LINE: begin
                we    = 1'b1;
                waddr = {clr_x, clr_row};
                wdata = BLANK;
            end
            CLR_ALL: begin
                we    = 1'b1;
                waddr = {clr_x, clr_y};
                wdata = BLANK;
            end
            default: ;
        endcase
    end

    // Screen RAM (no reset; blanked by the CLR_ALL sweep).
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read port with out-of-range cells returning zero.
    logic [XW-1:0] rd_x;
    logic [YW-1:0] rd_y;
    assign rd_x = vga_addr[AW-1:YW];
    assign rd_y = vga_addr[YW-1:0];

    always_comb begin
        vga_data = '0;
        if (rd_x < XW'(COLS) && rd_y < YW'(ROWS)) begin
            vga_data = mem[{rd_x, phys_row(rd_y, top)}];
        end
    end

    // Controller FSM, cursor and clear counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= CLR_ALL;
            top      <= '0;
            cursor_x <= '0;
            cursor_y <= '0;
            clr_x    <= '0;
            clr_y    <= '0;
            clr_row  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr_req) begin
                        state <= CLR_ALL;
                        clr_x <= '0;
                        clr_y <= '0;
                    end else if (accept_c) begin
                        if (newline_c) begin
                            cursor_x <= '0;
                            if (scroll_c) begin
                                // Old top row becomes the new bottom row; blank it.
                                top     <= (top == Y_LAST) ? '0 : top + YW'(1);
                                clr_row <= top;
                                clr_x   <= '0;
                                state   <= CLR_LINE;
                            end else begin
                                cursor_y <= cursor_y + YW'(1);
                            end
                        end else if (printable_c) begin
                            cursor_x <= cursor_x + XW'(1);
                        end else if (wr_char == 8'h0D) begin
                            cursor_x <= '0;
                        end else if (wr_char == 8'h08 && cursor_x != '0) begin
                            cursor_x <= cursor_x - XW'(1);
                        end
                    end
                end
                CLR_LINE: begin
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        state <= IDLE;
                    end else begin
                        clr_x <= clr_x + XW'(1);
                    end
                end
                CLR_ALL: begin
                    if (clr_x == X_LAST) begin
                        clr_x <= '0;
                        if (clr_y == Y_LAST) begin
                            clr_y    <= '0;
                            top      <= '0;
                            cursor_x <= '0;
                            cursor_y <= '0;
                            state    <= IDLE;
                        end else begin
                            clr_y <= clr_y + YW'(1);
                        end
                    end else begin
                        clr_x <= clr_x + XW'(1);
                    end
                end
                default: state <= CLR_ALL;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_text_ctrl.sv
// tb_vga_text_ctrl: self-checking bench for vga_text_ctrl. A logical-screen
// model (rows shifted on scroll) is checked against the DUT every cycle,
// alongside directed scenarios with literal expectations and a random phase.
module tb_vga_text_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] vga_addr;
    logic [31:0] vga_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [7:0]  wr_char;
    logic [11:0] wr_fg;
    logic [11:0] wr_bg;
    logic        clr_req;
    logic        busy;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;

    vga_text_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .vga_addr (vga_addr),
        .vga_data (vga_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_char  (wr_char),
        .wr_fg    (wr_fg),
        .wr_bg    (wr_bg),
        .clr_req  (clr_req),
        .busy     (busy),
        .cursor_x (cursor_x),
        .cursor_y (cursor_y)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: logical screen rows, cursor, remaining busy cycles.
    logic [31:0] scr [60][80];
    int          m_cx;
    int          m_cy;
    int          m_busy;
    bit          m_pend_all;

    task automatic m_newline();
        m_cx = 0;
        if (m_cy < 59) begin
            m_cy++;
        end else begin
            for (int r = 0; r < 59; r++)
                for (int c = 0; c < 80; c++) scr[r][c] = scr[r+1][c];
            for (int c = 0; c < 80; c++) scr[59][c] = 32'hFFF0_0020;
            m_busy = 80;
        end
    endtask

    task automatic m_apply(input logic [7:0] c, input logic [11:0] fg, input logic [11:0] bg);
        if (c >= 8'h20 && c != 8'h7F) begin
            scr[m_cy][m_cx] = {fg, bg, c};
            m_cx++;
            if (m_cx == 80) m_newline();
        end else if (c == 8'h0A) begin
            m_newline();
        end else if (c == 8'h0D) begin
            m_cx = 0;
        end else if (c == 8'h08 && m_cx > 0) begin
            m_cx--;
            scr[m_cy][m_cx] = {fg, bg, 8'h20};
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy     = 4800;
            m_pend_all = 1'b1;
            m_cx       = 0;
            m_cy       = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0 && m_pend_all) begin
                for (int r = 0; r < 60; r++)
                    for (int c = 0; c < 80; c++) scr[r][c] = 32'hFFF0_0020;
                m_cx       = 0;
                m_cy       = 0;
                m_pend_all = 1'b0;
            end
        end else if (clr_req) begin
            m_busy     = 4800;
            m_pend_all = 1'b1;
        end else if (wr_valid) begin
            m_apply(wr_char, wr_fg, wr_bg);
        end
    end

    function automatic logic [31:0] m_read(input logic [12:0] a);
        logic [6:0] x;
        logic [5:0] y;
        x = a[12:6];
        y = a[5:0];
        if (x >= 7'd80 || y >= 6'd60) return 32'h0;
        return scr[y][x];
    endfunction

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(m_busy > 0));
            chk("wr_ready", 32'(wr_ready), 32'(m_busy == 0 && !clr_req && !rst));
            if (m_busy == 0 && !rst) begin
                chk("cursor_x", 32'(cursor_x), 32'(m_cx));
                chk("cursor_y", 32'(cursor_y), 32'(m_cy));
                chk("vga_data", vga_data, m_read(vga_addr));
            end
        end
    end

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic probe(input logic [6:0] x, input logic [5:0] y);
        vga_addr = {x, y};
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] c, input logic [11:0] fg, input logic [11:0] bg);
        bit done;
        done     = 1'b0;
        wr_valid = 1'b1;
        wr_char  = c;
        wr_fg    = fg;
        wr_bg    = bg;
        for (int i = 0; i < 10000 && !done; i++) begin
            @(negedge clk);
            done = wr_ready;
            @(posedge clk);
            #1;
        end
        wr_valid = 1'b0;
        chk("send_accepted", 32'(done), 32'd1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        wr_valid = 1'b0;
        wr_char  = 8'h00;
        wr_fg    = 12'h000;
        wr_bg    = 12'h000;
        clr_req  = 1'b0;
        vga_addr = 13'h0;

        // Reset and initial sweep
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_en = 1'b1;
        count_busy(n);
        chk("reset_busy_cycles", 32'(n), 32'd4800);
        chk("ready_after_reset", 32'(wr_ready), 32'd1);
        realign();
        for (int y = 0; y < 60; y++)
            for (int x = 0; x < 80; x++) begin
                probe(7'(x), 6'(y));
                chk("blank_after_reset", vga_data, 32'hFFF0_0020);
                realign();
            end
        probe(7'd80, 6'd0);
        chk("x_out_of_range", vga_data, 32'h0);
        realign();
        probe(7'd0, 6'd60);
        chk("y_out_of_range", vga_data, 32'h0);
        realign();

        // Single character
        send(8'h61, 12'hF00, 12'h00F);
        probe(7'd0, 6'd0);
        chk("single_cell", vga_data, 32'hF000_0F61);
        chk("single_cx", 32'(cursor_x), 32'd1);
        chk("single_cy", 32'(cursor_y), 32'd0);
        realign();

        // Backspace, CR, ignored control code
        send(8'h62, 12'hF00, 12'h00F);
        send(8'h08, 12'hFFF, 12'h000);
        probe(7'd1, 6'd0);
        chk("bs_cell", vga_data, 32'hFFF0_0020);
        chk("bs_cx", 32'(cursor_x), 32'd1);
        realign();
        send(8'h0D, 12'h000, 12'h000);
        @(negedge clk);
        chk("cr_cx", 32'(cursor_x), 32'd0);
        realign();
        send(8'h01, 12'h000, 12'h000);
        @(negedge clk);
        chk("ctl_cx", 32'(cursor_x), 32'd0);
        chk("ctl_cy", 32'(cursor_y), 32'd0);
        realign();
        send(8'h08, 12'h000, 12'h000);
        @(negedge clk);
        chk("bs_at_x0", 32'(cursor_x), 32'd0);
        realign();

        // Line wrap
        for (int i = 0; i < 80; i++) send(8'h41, 12'h0F0, 12'h000);
        probe(7'd79, 6'd0);
        chk("wrap_cell", vga_data, 32'h0F00_0041);
        chk("wrap_cx", 32'(cursor_x), 32'd0);
        chk("wrap_cy", 32'(cursor_y), 32'd1);
        realign();

        // Scroll triggered by a printable at (79,59)
        for (int i = 0; i < 58; i++) send(8'h0A, 12'h000, 12'h000);
        for (int i = 0; i < 79; i++) send(8'h78, 12'h0FF, 12'h000);
        @(negedge clk);
        chk("pre_scroll_cx", 32'(cursor_x), 32'd79);
        chk("pre_scroll_cy", 32'(cursor_y), 32'd59);
        realign();
        send(8'h5A, 12'h00F, 12'h000);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (wr_ready) break;
            n++;
        end
        chk("scroll_ready_low", 32'(n), 32'd80);
        chk("scroll_cx", 32'(cursor_x), 32'd0);
        chk("scroll_cy", 32'(cursor_y), 32'd59);
        realign();
        probe(7'd79, 6'd58);
        chk("scroll_z_row58", vga_data, 32'h00F0_005A);
        realign();
        for (int x = 0; x < 80; x++) begin
            probe(7'(x), 6'd59);
            chk("scroll_row59_blank", vga_data, 32'hFFF0_0020);
            realign();
        end

        // clr_req beats wr_valid
        clr_req  = 1'b1;
        wr_valid = 1'b1;
        wr_char  = 8'h51;
        @(negedge clk);
        chk("clr_prio_ready", 32'(wr_ready), 32'd0);
        @(posedge clk);
        #1;
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        count_busy(n);
        chk("clr_busy_cycles", 32'(n), 32'd4800);
        realign();
        probe(7'd79, 6'd58);
        chk("clr_cell_blank", vga_data, 32'hFFF0_0020);
        chk("clr_cursor_x", 32'(cursor_x), 32'd0);
        chk("clr_cursor_y", 32'(cursor_y), 32'd0);
        realign();

        // Reset in the middle of a sweep
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (100) @(negedge clk);
        realign();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        count_busy(n);
        chk("midsweep_busy_cycles", 32'(n), 32'd4800);
        realign();

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            vga_addr = 13'($urandom);
            wr_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 15);
            case (r)
                0, 1:    wr_char = 8'h0A;
                2:       wr_char = 8'h0D;
                3:       wr_char = 8'h08;
                4:       wr_char = 8'($urandom_range(0, 31));
                5:       wr_char = 8'h7F;
                default: wr_char = 8'($urandom_range(32, 255));
            endcase
            wr_fg   = 12'($urandom);
            wr_bg   = 12'($urandom);
            clr_req = ($urandom_range(0, 1499) == 0);
            realign();
        end
        clr_req  = 1'b0;
        wr_valid = 1'b0;
        count_busy(n);
        chk("final_idle", 32'(busy), 32'd0);
        for (int i = 0; i < 200; i++) begin
            realign();
            vga_addr = 13'($urandom);
        end
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
